seq_detect_ctrl: RTL

Programmable serial-pattern detection controller for the single-bit input stream on ui_in[0].
- Accepts a pattern configuration through a valid/ready handshake.
- Arms and disarms detection, and selects overlapping or non-overlapping matching.
- Counts matches and stops detection when a programmable match limit is reached.
- Reset defaults reproduce the current fixed 11011 non-overlapping detector, so it drops into the top level unchanged.

---
 rtl/seq_detect_ctrl.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/seq_detect_ctrl.sv
// Programmable serial-pattern detector on a single-bit stream with a
// valid/ready configuration port, match counting and a stop-on-limit option.
module seq_detect_ctrl #(
  parameter int MAX_LEN = 8,
  parameter int CNT_W   = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         cfg_valid,
  output logic                         cfg_ready,
  input  logic [MAX_LEN-1:0]           cfg_pattern,
  input  logic [$clog2(MAX_LEN+1)-1:0] cfg_len,
  input  logic                         cfg_overlap,
  input  logic [CNT_W-1:0]             cfg_limit,
  output logic                         cfg_err,
  input  logic                         arm,
  input  logic                         bit_valid,
  input  logic                         bit_in,
  output logic                         match,
  output logic [CNT_W-1:0]             match_count,
  output logic                         busy,
  output logic                         done
);

  localparam int LEN_W = $clog2(MAX_LEN+1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ARMED = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  // Reset configuration reproduces the legacy fixed 11011 non-overlapping detector.
  localparam logic [MAX_LEN-1:0] DEF_PAT = MAX_LEN'(5'b11011);
  localparam logic [LEN_W-1:0]   DEF_LEN = LEN_W'(5);

  logic [1:0]         state_r;
  logic [MAX_LEN-1:0] pat_r;
  logic [LEN_W-1:0]   len_r;
  logic               ovl_r;
  logic [CNT_W-1:0]   lim_r;
  logic [MAX_LEN-1:0] hist_r;
  logic [LEN_W-1:0]   fill_r;
  logic [CNT_W-1:0]   cnt_r;
  logic               match_r;
  logic               err_r;
  logic               busy_r;
  logic               done_r;

  logic [MAX_LEN-1:0] nh_s;
  logic [MAX_LEN-1:0] mask_s;
  logic [LEN_W-1:0]   fill_inc_s;
  logic [CNT_W-1:0]   cnt_inc_s;
  logic               fill_ok_s;
  logic               hit_s;
  logic               len_ok_s;

  // Candidate history, compare mask, saturating increments and hit detection.
  always_comb begin
    nh_s       = {hist_r[MAX_LEN-2:0], bit_in};
    mask_s     = {MAX_LEN{1'b0}};
    for (int i = 0; i < MAX_LEN; i++) begin
      mask_s[i] = (LEN_W'(i) < len_r);
    end
    fill_inc_s = (fill_r >= len_r) ? len_r : fill_r + LEN_W'(1);
    cnt_inc_s  = (cnt_r == {CNT_W{1'b1}}) ? cnt_r : cnt_r + CNT_W'(1);
    fill_ok_s  = (({1'b0, fill_r} + (LEN_W+1)'(1)) >= {1'b0, len_r});
    hit_s      = fill_ok_s && (((nh_s ^ pat_r) & mask_s) == {MAX_LEN{1'b0}});
    len_ok_s   = (cfg_len != {LEN_W{1'b0}}) && (cfg_len <= LEN_W'(MAX_LEN));
  end

  // Controller state, configuration registers, shift history and counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      pat_r   <= DEF_PAT;
      len_r   <= DEF_LEN;
      ovl_r   <= 1'b0;
      lim_r   <= {CNT_W{1'b0}};
      hist_r  <= {MAX_LEN{1'b0}};
      fill_r  <= {LEN_W{1'b0}};
      cnt_r   <= {CNT_W{1'b0}};
      match_r <= 1'b0;
      err_r   <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      match_r <= 1'b0;
      err_r   <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (cfg_valid) begin
            // Configuration takes priority; a simultaneous arm waits a cycle.
            if (len_ok_s) begin
              pat_r <= cfg_pattern;
              len_r <= cfg_len;
              ovl_r <= cfg_overlap;
              lim_r <= cfg_limit;
            end else begin
              err_r <= 1'b1;
            end
          end else if (arm) begin
            state_r <= ST_ARMED;
            cnt_r   <= {CNT_W{1'b0}};
            hist_r  <= {MAX_LEN{1'b0}};
            fill_r  <= {LEN_W{1'b0}};
            busy_r  <= 1'b1;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_ARMED: begin
          if (!arm) begin
            state_r <= ST_IDLE;
            hist_r  <= {MAX_LEN{1'b0}};
            fill_r  <= {LEN_W{1'b0}};
            busy_r  <= 1'b0;
          end else if (bit_valid) begin
            hist_r <= nh_s;
            if (hit_s) begin
              match_r <= 1'b1;
              cnt_r   <= cnt_inc_s;
              fill_r  <= ovl_r ? fill_inc_s : {LEN_W{1'b0}};
              if ((lim_r != {CNT_W{1'b0}}) && (cnt_inc_s == lim_r)) begin
                state_r <= ST_DONE;
                done_r  <= 1'b1;
              end else begin
                state_r <= ST_ARMED;
              end
            end else begin
              fill_r <= fill_inc_s;
            end
          end else begin
            state_r <= ST_ARMED;
          end
        end
        ST_DONE: begin
          if (!arm) begin
            state_r <= ST_IDLE;
            hist_r  <= {MAX_LEN{1'b0}};
            fill_r  <= {LEN_W{1'b0}};
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
          end else begin
            state_r <= ST_DONE;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
        end
      endcase
    end
  end

  assign cfg_ready   = (state_r == ST_IDLE);
  assign cfg_err     = err_r;
  assign match       = match_r;
  assign match_count = cnt_r;
  assign busy        = busy_r;
  assign done        = done_r;

endmodule
